// File: rtl/muldiv_if.sv
// Handshake and result bundle between the EX stage and the iterative
// multiply/divide sequencer.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Ex_md_start;
  logic [2:0]       Ex_md_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ex_md_flush;
  logic             Ex_md_busy;
  logic             Ex_md_done;
  logic             Ex_div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output Ex_md_start, Ex_md_op, A, B, Ex_md_flush,
    input  Ex_md_busy, Ex_md_done, Ex_div_zero, hi, lo
  );

  modport slave (
    input  Ex_md_start, Ex_md_op, A, B, Ex_md_flush,
    output Ex_md_busy, Ex_md_done, Ex_div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one iteration per
// cycle, shift-add multiply and restoring divide share one work register.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  md
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    work_q, work_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Operand magnitudes for the signed ops
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = md.A[WIDTH-1];
  assign b_neg = md.B[WIDTH-1];
  assign a_mag = a_neg ? -md.A : md.A;
  assign b_mag = b_neg ? -md.B : md.B;

  // Shift-add step: work = {partial product, remaining multiplier bits}
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  assign mul_sum  = {1'b0, work_q[W2-1:WIDTH]} + {1'b0, (work_q[0] ? opnd_q : '0)};
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  // Restoring step: work = {partial remainder, dividend bits / quotient bits}
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [W2-1:0]    div_next;
  assign div_shift = work_q[W2-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      work_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (md.Ex_md_start && !md.Ex_md_flush) begin
          cnt_d = '0;
          unique case (md.Ex_md_op)
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              qneg_d  = (md.Ex_md_op == OP_MULT) && (a_neg ^ b_neg);
              rneg_d  = 1'b0;
              opnd_d  = (md.Ex_md_op == OP_MULT) ? a_mag : md.A;
              work_d  = {{WIDTH{1'b0}}, ((md.Ex_md_op == OP_MULT) ? b_mag : md.B)};
            end
            OP_DIV, OP_DIVU: begin
              if (md.B == '0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                dz_d    = 1'b1;
              end else begin
                state_d = S_DIV;
                qneg_d  = (md.Ex_md_op == OP_DIV) && (a_neg ^ b_neg);
                rneg_d  = (md.Ex_md_op == OP_DIV) && a_neg;
                opnd_d  = (md.Ex_md_op == OP_DIV) ? b_mag : md.B;
                work_d  = {{WIDTH{1'b0}}, ((md.Ex_md_op == OP_DIV) ? a_mag : md.A)};
              end
            end
            OP_MTHI: hi_d = md.A;
            OP_MTLO: lo_d = md.A;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (md.Ex_md_flush) begin
          state_d = S_IDLE;
        end else begin
          work_d = mul_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IT) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            {hi_d, lo_d} = qneg_q ? -mul_next : mul_next;
          end
        end
      end
      S_DIV: begin
        if (md.Ex_md_flush) begin
          state_d = S_IDLE;
        end else begin
          work_d = div_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IT) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            lo_d    = qneg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
            hi_d    = rneg_q ? -div_next[W2-1:WIDTH] : div_next[W2-1:WIDTH];
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign md.Ex_md_busy  = (state_q != S_IDLE);
  assign md.Ex_md_done  = done_q;
  assign md.Ex_div_zero = dz_q;
  assign md.hi          = hi_q;
  assign md.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed ops push expected HI/LO results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && bus.Ex_md_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("div_zero", 32'(bus.Ex_div_zero), 32'(e.dz));
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Ex_md_start = 1'b1;
    bus.Ex_md_op    = op;
    bus.A           = a;
    bus.B           = b;
    @(posedge clk);
    #1;
    bus.Ex_md_start = 1'b0;
  endtask

  // Counts busy cycles after issue; bounded so a stuck unit still reaches the summary
  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.Ex_md_busy) return;
      cycles++;
    end
    n_checks++;
    n_errors++;
    $display("FAIL busy_timeout: got busy after %0d cycles expected idle", cycles);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic dz, input logic [31:0] hi,
                        input logic [31:0] lo, input int busy_len);
    int cyc;
    exp_t e;
    e.dz = dz; e.hi = hi; e.lo = lo;
    exp_q.push_back(e);
    issue(op, a, b);
    wait_idle(cyc);
    chk({name, "_busy_len"}, 32'(cyc), 32'(busy_len));
    chk({name, "_hi_after"}, bus.hi, hi);
    chk({name, "_lo_after"}, bus.lo, lo);
  endtask

  initial begin
    int cyc;
    bus.Ex_md_start = 1'b0;
    bus.Ex_md_op    = 3'b000;
    bus.A           = '0;
    bus.B           = '0;
    bus.Ex_md_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", 32'(bus.Ex_md_busy), 32'h0);
    chk("rst_done", 32'(bus.Ex_md_done), 32'h0);
    chk("rst_dz", 32'(bus.Ex_div_zero), 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mult_neg",  3'b000, 32'hFFFFFFFF, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("multu",     3'b001, 32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h00000001, 32'hFFFFFFFE, 33);
    run_op("mult_3x4",  3'b000, 32'h00000003, 32'h00000004, 1'b0, 32'h00000000, 32'h0000000C, 33);
    run_op("div_neg",   3'b010, 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_op("divu",      3'b011, 32'h00000007, 32'h00000002, 1'b0, 32'h00000001, 32'h00000003, 33);
    run_op("div_negb",  3'b010, 32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 33);
    run_op("div_wrap",  3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 33);

    // MTHI/MTLO never raise busy
    issue(3'b100, 32'h55555555, 32'h0);
    @(negedge clk);
    chk("mthi_busy", 32'(bus.Ex_md_busy), 32'h0);
    chk("mthi_hi", bus.hi, 32'h55555555);
    @(posedge clk); #1;
    issue(3'b101, 32'h55555555, 32'h0);
    @(negedge clk);
    chk("mtlo_busy", 32'(bus.Ex_md_busy), 32'h0);
    chk("mtlo_lo", bus.lo, 32'h55555555);
    @(posedge clk); #1;

    run_op("divu_zero", 3'b011, 32'h00000007, 32'h00000000, 1'b1, 32'h55555555, 32'h55555555, 1);

    // MULT aborted by flush on the 10th iteration cycle; start while busy is ignored
    issue(3'b000, 32'h00000003, 32'h00000004);
    bus.Ex_md_start = 1'b1;
    bus.Ex_md_op    = 3'b100;
    bus.A           = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 bus.Ex_md_start = 1'b0;
    repeat (6) @(posedge clk);
    #1 bus.Ex_md_flush = 1'b1;
    @(posedge clk);
    #1 bus.Ex_md_flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(bus.Ex_md_busy), 32'h0);
    chk("flush_hi", bus.hi, 32'h55555555);
    chk("flush_lo", bus.lo, 32'h55555555);
    repeat (40) @(posedge clk);
    #1;

    // Flush together with start in IDLE discards the op
    bus.Ex_md_flush = 1'b1;
    issue(3'b101, 32'hCAFEF00D, 32'h0);
    bus.Ex_md_flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_lo", bus.lo, 32'h55555555);
    chk("flush_idle_busy", 32'(bus.Ex_md_busy), 32'h0);
    @(posedge clk); #1;

    issue(3'b100, 32'h12345678, 32'h0);
    @(negedge clk);
    chk("mthi2_hi", bus.hi, 32'h12345678);
    chk("mthi2_busy", 32'(bus.Ex_md_busy), 32'h0);
    @(posedge clk); #1;

    // Opcode 110 is ignored
    issue(3'b110, 32'hFFFFFFFF, 32'h00000003);
    @(negedge clk);
    chk("op110_busy", 32'(bus.Ex_md_busy), 32'h0);
    chk("op110_hi", bus.hi, 32'h12345678);
    @(posedge clk); #1;

    // Reset in the middle of a DIV
    issue(3'b010, 32'h00000064, 32'h00000003);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_hi", bus.hi, 32'h0);
    chk("midrst_lo", bus.lo, 32'h0);
    chk("midrst_busy", 32'(bus.Ex_md_busy), 32'h0);
    chk("midrst_done", 32'(bus.Ex_md_done), 32'h0);
    chk("midrst_dz", 32'(bus.Ex_div_zero), 32'h0);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("midrst_stays_idle", 32'(bus.Ex_md_busy), 32'h0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
